mioc_flop_seq: RTL and testbench
================================

MIOC_FLOP_SEQ -- requirements
Module: mioc_flop_seq

Interface
REQ-001 Parameter PW_W, default 4: width of the pulse-width config field.
REQ-002 Parameter ST_W, default 4: width of the settle-count config field.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1 each  level request from requester 0 / 1.
REQ-006 op0, op1  in  1 each  operation per requester: 1=set, 0=clear; sampled with grant.
REQ-007 gnt  out  2  one-hot, one-cycle grant pulse; bit n = requester n accepted.
REQ-008 cfg_pw  in  PW_W  drive pulse width in cycles; 0 is treated as 1.
REQ-009 cfg_settle  in  ST_W  settle cycles after the pulse; 0 is allowed.
REQ-010 q_fb  in  1  flop q output fed back for verification.
REQ-011 fl_in1, fl_in2, fl_in3, fl_in4  out  1 each  flop drive: posedge reset, negedge reset, inverted negedge reset, posedge set.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  valid with done; 1 = q_fb mismatched the requested op.
REQ-015 owner  out  1  index of the requester owning the current operation; valid while busy.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE; all outputs are registered.
REQ-017 Idle drive levels SHALL be fl_in1=0, fl_in2=1, fl_in3=0, fl_in4=0 in every state except DRIVE.
REQ-018 IDLE with any req high: at the next edge, assert gnt for one cycle, latch the op, owner, max(cfg_pw,1) and cfg_settle, and enter DRIVE.
REQ-019 Arbitration SHALL be round-robin: a single request is granted; with both requests high, grant the requester not granted last.
REQ-020 DRIVE set: fl_in4=1 for exactly PW cycles; other drive pins stay at idle levels.
REQ-021 DRIVE clear: fl_in1=1, fl_in2=0, fl_in3=1 simultaneously for exactly PW cycles; fl_in4=0.
REQ-022 fl_in1/fl_in2/fl_in3 and fl_in4 SHALL never be active in the same cycle.
REQ-023 After DRIVE, SETTLE SHALL last cfg_settle cycles; with 0, go directly to CHECK.
REQ-024 CHECK (one cycle) SHALL sample q_fb; err_next = (q_fb != latched op).
REQ-025 DONE (one cycle) SHALL assert done together with err, then return to IDLE; no grant is issued in DONE.
REQ-026 Latency from the gnt cycle to the done cycle SHALL be PW+S+1 cycles (gnt in cycle 0).
REQ-027 Requests arriving while busy SHALL be held off; a requester SHALL drop req the cycle after gnt, otherwise it is re-arbitrated from IDLE.
REQ-028 Config changes while busy SHALL have no effect on the current operation.
REQ-029 Counters SHALL saturate-safe decrement; no wrap-around at 0.

Reset
REQ-030 When reset is high at a clock edge, the next state SHALL be IDLE, gnt=00, done=0, err=0, busy=0, owner=0, and drive pins at idle levels.
REQ-031 Reset SHALL abort an operation in progress without emitting done, and drive pins return to idle levels on that same edge.
REQ-032 The round-robin pointer SHALL reset so that requester 0 wins the first simultaneous request.

Structure
REQ-033 Package mioc_flop_pkg SHALL hold the state enum, OP_SET/OP_CLR encodings and the idle drive-level constants.
REQ-034 The round-robin arbiter SHALL be a sub-module mioc_rr_arb2 (request pair in; one-hot grant and last-grant pointer out).

Verification
REQ-035 Set with cfg_pw=2, cfg_settle=3, q_fb=1: req0/op0=1 -> gnt=01; fl_in4 high 2 cycles; done in cycle 6 after gnt; err=0.
REQ-036 Clear with cfg_pw=0, cfg_settle=0, q_fb stuck 1: fl_in1=1/fl_in2=0/fl_in3=1 for 1 cycle; done 2 cycles after gnt; err=1.
REQ-037 req0 and req1 held high continuously -> grants alternate 01,10,01 starting with 01 after reset; never two grants without an intervening done.
REQ-038 Reset asserted mid-DRIVE: drive pins return to idle levels and busy=0 on the next edge; no done is emitted.
REQ-039 cfg_pw changed from 2 to 7 during DRIVE -> the pulse stays exactly 2 cycles; a checker asserts REQ-022 over the entire run.

Source files
------------

// File: rtl/mioc_flop_pkg.sv
// Shared types and constants for the flop-sequencing controller.
package mioc_flop_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  // Idle drive levels for fl_in1..fl_in4
  localparam logic FL1_IDLE = 1'b0;
  localparam logic FL2_IDLE = 1'b1;
  localparam logic FL3_IDLE = 1'b0;
  localparam logic FL4_IDLE = 1'b0;

  // Drive vectors packed as {fl_in4, fl_in3, fl_in2, fl_in1}
  localparam logic [3:0] FL_IDLE = {FL4_IDLE, FL3_IDLE, FL2_IDLE, FL1_IDLE};
  localparam logic [3:0] FL_SET  = {1'b1, FL3_IDLE, FL2_IDLE, FL1_IDLE};
  localparam logic [3:0] FL_CLR  = {FL4_IDLE, 1'b1, 1'b0, 1'b1};

  // Set pulses only the posedge-set pin; clear pulses all three reset pins
  function automatic logic [3:0] fl_drive(input logic op);
    return (op == OP_SET) ? FL_SET : FL_CLR;
  endfunction

endpackage

// File: rtl/mioc_rr_arb2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, registered
// last-grant pointer that only moves when the grant is actually taken.
module mioc_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       last
);

  // A lone request wins outright; on contention the one not granted last wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  // Reset as if requester 1 went last so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset)                 last <= 1'b1;
    else if (accept && |gnt)   last <= gnt[1];
  end

endmodule

// File: rtl/mioc_flop_seq.sv
// Flop set/clear sequencer: arbitrates two requesters, pulses the flop drive
// pins for a configured width, waits a settle time, then checks q feedback.
module mioc_flop_seq
  import mioc_flop_pkg::*;
#(
  parameter int PW_W = 4,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            op0,
  input  logic            op1,
  output logic [1:0]      gnt,
  input  logic [PW_W-1:0] cfg_pw,
  input  logic [ST_W-1:0] cfg_settle,
  input  logic            q_fb,
  output logic            fl_in1,
  output logic            fl_in2,
  output logic            fl_in3,
  output logic            fl_in4,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            owner
);

  state_t          state;
  logic            op_q;
  logic [PW_W-1:0] pw_cnt;
  logic [ST_W-1:0] st_cnt;
  logic [3:0]      fl_q;
  logic [1:0]      arb_gnt;
  logic            rr_last_unused;

  mioc_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .accept (state == S_IDLE),
    .gnt    (arb_gnt),
    .last   (rr_last_unused)
  );

  assign fl_in1 = fl_q[0];
  assign fl_in2 = fl_q[1];
  assign fl_in3 = fl_q[2];
  assign fl_in4 = fl_q[3];

  // Sequencer FSM; every output is a register updated here
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      gnt    <= 2'b00;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b0;
      op_q   <= OP_CLR;
      pw_cnt <= '0;
      st_cnt <= '0;
      fl_q   <= FL_IDLE;
    end else begin
      gnt  <= 2'b00;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|arb_gnt) begin
            // Latch everything now so later req/cfg changes cannot disturb us
            gnt    <= arb_gnt;
            owner  <= arb_gnt[1];
            op_q   <= arb_gnt[1] ? op1 : op0;
            pw_cnt <= (cfg_pw == '0) ? PW_W'(1) : cfg_pw;
            st_cnt <= cfg_settle;
            fl_q   <= fl_drive(arb_gnt[1] ? op1 : op0);
            busy   <= 1'b1;
            state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (pw_cnt <= PW_W'(1)) begin
            pw_cnt <= '0;
            fl_q   <= FL_IDLE;
            state  <= (st_cnt == '0) ? S_CHECK : S_SETTLE;
          end else begin
            pw_cnt <= pw_cnt - PW_W'(1);
          end
        end
        S_SETTLE: begin
          if (st_cnt <= ST_W'(1)) begin
            st_cnt <= '0;
            state  <= S_CHECK;
          end else begin
            st_cnt <= st_cnt - ST_W'(1);
          end
        end
        S_CHECK: begin
          err   <= (q_fb != op_q);
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          fl_q  <= FL_IDLE;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mioc_flop_seq.sv
// Randomised bench for mioc_flop_seq with a transaction-level reference model
// plus directed scenarios with hand-computed expectations.
module tb_mioc_flop_seq;

  localparam int PW_W = 4;
  localparam int ST_W = 4;

  logic            clk = 1'b0;
  logic            reset, req0, req1, op0, op1, q_fb;
  logic [PW_W-1:0] cfg_pw;
  logic [ST_W-1:0] cfg_settle;
  logic [1:0]      gnt;
  logic            fl_in1, fl_in2, fl_in3, fl_in4, busy, done, err, owner;

  int errors = 0;
  int checks = 0;

  mioc_flop_seq #(.PW_W(PW_W), .ST_W(ST_W)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .gnt(gnt), .cfg_pw(cfg_pw), .cfg_settle(cfg_settle), .q_fb(q_fb),
    .fl_in1(fl_in1), .fl_in2(fl_in2), .fl_in3(fl_in3), .fl_in4(fl_in4),
    .busy(busy), .done(done), .err(err), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One transaction at a time, described by its start cycle offset k.
  // Cycle k=0 carries gnt, drive for k<pw, check at k=pw+s, done at k=pw+s+1.
  bit m_active, m_last, m_own, m_op, m_errv;
  int m_k, m_pw, m_s;
  logic [1:0] e_gnt;
  logic [3:0] e_fl;   // {fl4, fl3, fl2, fl1}
  logic e_busy, e_done, e_err;

  task automatic model_step();
    if (reset) begin
      m_active = 0; m_last = 1; m_own = 0;
    end else if (m_active) begin
      if (m_k == m_pw + m_s) m_errv = (q_fb != m_op);
      if (m_k == m_pw + m_s + 1) m_active = 0;
      else m_k++;
    end else if (req0 || req1) begin
      m_own  = (req0 && req1) ? ~m_last : req1;
      m_last = m_own;
      m_op   = m_own ? op1 : op0;
      m_pw   = (cfg_pw == 0) ? 1 : int'(cfg_pw);
      m_s    = int'(cfg_settle);
      m_k    = 0;
      m_active = 1;
    end
    e_gnt = 2'b00; e_fl = 4'b0010; e_busy = 0; e_done = 0; e_err = 0;
    if (m_active) begin
      e_busy = 1;
      if (m_k == 0) e_gnt = m_own ? 2'b10 : 2'b01;
      if (m_k < m_pw) e_fl = m_op ? 4'b1010 : 4'b0101;
      if (m_k == m_pw + m_s + 1) begin e_done = 1; e_err = m_errv; end
    end
  endtask

  // Per-cycle compare against the model, sampled 1ns after the edge
  always @(posedge clk) begin
    model_step();
    #1;
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("fl", 32'({fl_in4, fl_in3, fl_in2, fl_in1}), 32'(e_fl));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    if (e_busy) chk("owner", 32'(owner), 32'(m_own));
    // set drive and clear drive never overlap
    chk("drive_exclusive", 32'(fl_in4 && (fl_in1 || !fl_in2 || fl_in3)), 32'(0));
  end

  // ---------------- directed helpers ----------------
  task automatic directed(input string nm, input bit who, input bit op, input int pw,
                          input int st, input bit qf, input int new_pw,
                          input int exp_lat, input int exp_pulse, input bit exp_err);
    bit got, seen;
    int pulse, lat;
    @(negedge clk);
    cfg_pw = PW_W'(pw); cfg_settle = ST_W'(st); q_fb = qf;
    op0 = op; op1 = op;
    req0 = !who; req1 = who;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1;
    end
    chk({nm, "_gnt_seen"}, 32'(got), 32'(1));
    chk({nm, "_gnt"}, 32'(gnt), who ? 32'(2) : 32'(1));
    req0 = 0; req1 = 0;
    pulse = 0; lat = -1; seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (op ? fl_in4 : (fl_in1 && !fl_in2 && fl_in3)) pulse++;
      if (done) begin
        seen = 1; lat = k;
        chk({nm, "_err"}, 32'(err), 32'(exp_err));
      end else begin
        if (k == 0 && new_pw >= 0) cfg_pw = PW_W'(new_pw);
        @(negedge clk);
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_pulse"}, 32'(pulse), 32'(exp_pulse));
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; req0 = 0; req1 = 0;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; req0 = 0; req1 = 0; op0 = 0; op1 = 0; q_fb = 0;
    cfg_pw = '0; cfg_settle = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({gnt, fl_in4, fl_in3, fl_in2, fl_in1, busy, done, err, owner}),
        32'({2'b00, 4'b0010, 4'b0000}));
    reset = 0;

    // Set, pw=2 settle=3, q=1: done 6 cycles after gnt, 2-cycle pulse, no err
    directed("set_pw2_st3", 0, 1, 2, 3, 1, -1, 6, 2, 0);
    // Clear, pw=0 settle=0, q stuck 1: done 2 cycles after gnt, err
    directed("clr_pw0_st0", 0, 0, 0, 0, 1, -1, 2, 1, 1);
    // Requester 1 set with q=0: err, latency 1+2+1
    directed("r1_set_bad_q", 1, 1, 1, 2, 0, -1, 4, 1, 1);
    // cfg_pw raised during DRIVE must not stretch the pulse
    directed("pw_change", 0, 1, 2, 0, 1, 7, 3, 2, 0);
    // Max pulse width and settle
    directed("clr_max", 1, 0, 15, 15, 0, -1, 31, 15, 0);

    // Both requests held: alternate 01,10,01 after reset
    begin
      logic [1:0] seq [3];
      int ng;
      do_reset();
      op0 = 1; op1 = 0; cfg_pw = 4'd1; cfg_settle = 4'd1; q_fb = 1;
      req0 = 1; req1 = 1;
      ng = 0;
      for (int n = 0; n < 100 && ng < 3; n++) begin
        @(negedge clk);
        if (gnt != 2'b00) begin seq[ng] = gnt; ng++; end
      end
      req0 = 0; req1 = 0;
      chk("rr_count", 32'(ng), 32'(3));
      chk("rr_g0", 32'(seq[0]), 32'(2'b01));
      chk("rr_g1", 32'(seq[1]), 32'(2'b10));
      chk("rr_g2", 32'(seq[2]), 32'(2'b01));
      repeat (6) @(negedge clk);
    end

    // Reset in the middle of DRIVE aborts without done
    begin
      bit seen;
      int n;
      @(negedge clk);
      cfg_pw = 4'd5; cfg_settle = 4'd2; op0 = 1; req0 = 1;
      n = 0;
      while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
      chk("abort_gnt_seen", 32'(gnt), 32'(2'b01));
      req0 = 0;
      @(negedge clk);
      chk("abort_in_drive", 32'(fl_in4), 32'(1));
      reset = 1;
      @(negedge clk);
      reset = 0;
      chk("abort_idle", 32'({fl_in4, fl_in3, fl_in2, fl_in1, busy, done}), 32'(6'b0010_00));
      seen = 0;
      repeat (12) begin @(negedge clk); if (done) seen = 1; end
      chk("abort_no_done", 32'(seen), 32'(0));
    end

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 249) == 0);
      req0       = ($urandom_range(0, 2) != 0);
      req1       = ($urandom_range(0, 2) != 0);
      op0        = 1'($urandom);
      op1        = 1'($urandom);
      cfg_pw     = PW_W'($urandom_range(0, 5));
      cfg_settle = ST_W'($urandom_range(0, 4));
      q_fb       = 1'($urandom);
    end
    reset = 0; req0 = 0; req1 = 0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
